// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser plus per-key debounce FSM with press/release pulses.
// Optional one-shot long-press pulse when KEY_LONG_PRESS_EN is defined.
module key_debounce #(
  parameter int KEY_NUM      = 3,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int LONG_CYC     = 50000000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [KEY_NUM-1:0] KEY_IN,
  output logic [KEY_NUM-1:0] KEY_STATE,
  output logic [KEY_NUM-1:0] KEY_PRESS,
  output logic [KEY_NUM-1:0] KEY_RELEASE,
  output logic [KEY_NUM-1:0] KEY_LONG
);

  localparam int MAX_CYC =
    (DEBOUNCE_CYC > LONG_CYC) ? DEBOUNCE_CYC : LONG_CYC;
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] D_LAST = CW'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [KEY_NUM-1:0] sync1;
  logic [KEY_NUM-1:0] sync2;

  // Synchroniser idles at 1: a reset looks like all keys released.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= KEY_IN;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
    state_t        st;
    state_t        st_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          s;
    logic          held;
    logic          press_start;
    logic          rel_start;
    logic          press_ev;
    logic          rel_ev;
    logic          state_q;
    logic          press_q;
    logic          rel_q;

    assign s    = sync2[i];
    assign held = (st == PRESSED) || (st == RELEASE_WAIT);

    always_comb begin
      st_nx  = st;
      cnt_nx = cnt;
      unique case (st)
        IDLE: begin
          if (!s) begin
            st_nx  = PRESS_WAIT;
            cnt_nx = '0;
          end
        end
        PRESS_WAIT: begin
          if (s) begin
            st_nx = IDLE;
          end else if (cnt == D_LAST) begin
            st_nx  = PRESSED;
            cnt_nx = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (s) begin
            st_nx  = RELEASE_WAIT;
            cnt_nx = '0;
          end
        end
        RELEASE_WAIT: begin
          if (!s) begin
            st_nx = PRESSED;
          end else if (cnt == D_LAST) begin
            st_nx  = IDLE;
            cnt_nx = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      endcase
    end

    assign press_start = (st == PRESS_WAIT) && (st_nx == PRESSED);
    assign rel_start   = (st == RELEASE_WAIT) && (st_nx == IDLE);

    // Events are captured on the transition and re-registered to outputs.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        st       <= IDLE;
        cnt      <= '0;
        press_ev <= 1'b0;
        rel_ev   <= 1'b0;
        state_q  <= 1'b0;
        press_q  <= 1'b0;
        rel_q    <= 1'b0;
      end else begin
        st       <= st_nx;
        cnt      <= cnt_nx;
        press_ev <= press_start;
        rel_ev   <= rel_start;
        state_q  <= held;
        press_q  <= press_ev;
        rel_q    <= rel_ev;
      end
    end

    assign KEY_STATE[i]   = state_q;
    assign KEY_PRESS[i]   = press_q;
    assign KEY_RELEASE[i] = rel_q;

`ifdef KEY_LONG_PRESS_EN
    localparam logic [CW-1:0] L_LAST = CW'(LONG_CYC - 1);
    logic [CW-1:0] hold;
    logic          fired;
    logic          long_hit;
    logic          long_ev;
    logic          long_q;

    assign long_hit = held && (hold == L_LAST) && !fired;

    // Hold counter saturates at L_LAST; fired blocks repeats until re-press.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        hold    <= '0;
        fired   <= 1'b0;
        long_ev <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        if (press_start) begin
          hold  <= '0;
          fired <= 1'b0;
        end else begin
          if (held && (hold != L_LAST)) begin
            hold <= hold + 1'b1;
          end
          if (long_hit) begin
            fired <= 1'b1;
          end
        end
        long_ev <= long_hit;
        long_q  <= long_ev;
      end
    end

    assign KEY_LONG[i] = long_q;
`else
    assign KEY_LONG[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: random + directed stimulus against a run-length debounce model.
// Expected outputs are queued per cycle and checked by an independent monitor.
module tb_key_debounce;

  localparam int N  = 3;
  localparam int D  = 8;
  localparam int L  = 20;

  logic         clk;
  logic         rst;
  logic [N-1:0] key_in;
  logic [N-1:0] key_state;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;
  logic [N-1:0] key_long;

  key_debounce #(
    .KEY_NUM     (N),
    .DEBOUNCE_CYC(D),
    .LONG_CYC    (L)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .KEY_IN     (key_in),
    .KEY_STATE  (key_state),
    .KEY_PRESS  (key_press),
    .KEY_RELEASE(key_release),
    .KEY_LONG   (key_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] st;
    logic [N-1:0] pr;
    logic [N-1:0] rl;
    logic [N-1:0] lg;
  } exp_t;

  exp_t q[$];
  int   tests;
  int   fails;
  bit   done;

  // Model: raw pins delayed two samples; a level flips after D+1
  // consecutive samples disagreeing with it; outputs lag one more cycle.
  logic [N-1:0] d1, d2, lvl, pev, rev, lev;
  int           run[N];
  int           pc[N];
  bit           fired[N];

  task automatic model_step(input logic [N-1:0] k, input logic r);
    exp_t         e;
    logic [N-1:0] s;
    if (r) begin
      d1 = '1; d2 = '1; lvl = '0;
      pev = '0; rev = '0; lev = '0;
      for (int i = 0; i < N; i++) begin
        run[i] = 0; pc[i] = 0; fired[i] = 0;
      end
      e = '0;
      q.push_back(e);
      return;
    end
    e.st = lvl;
    e.pr = pev;
    e.rl = rev;
`ifdef KEY_LONG_PRESS_EN
    e.lg = lev;
`else
    e.lg = '0;
`endif
    q.push_back(e);
    s  = d2;
    d2 = d1;
    d1 = k;
    pev = '0; rev = '0; lev = '0;
    for (int i = 0; i < N; i++) begin
      if (lvl[i]) begin
        pc[i]++;
        if (pc[i] == L && !fired[i]) begin
          lev[i]   = 1'b1;
          fired[i] = 1;
        end
      end
      if ((!s[i]) != lvl[i]) begin
        run[i]++;
        if (run[i] == D + 1) begin
          lvl[i] = ~lvl[i];
          run[i] = 0;
          if (lvl[i]) begin
            pev[i]   = 1'b1;
            pc[i]    = 0;
            fired[i] = 0;
          end else begin
            rev[i] = 1'b1;
          end
        end
      end else begin
        run[i] = 0;
      end
    end
  endtask

  task automatic cyc(input logic [N-1:0] k, input logic r, input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      key_in = k;
      rst    = r;
      model_step(k, r);
    end
  endtask

  task automatic chk(input string nm, input logic [N-1:0] a,
                     input logic [N-1:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, a, x);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("key_state", key_state, e.st);
        chk("key_press", key_press, e.pr);
        chk("key_release", key_release, e.rl);
        chk("key_long", key_long, e.lg);
      end
    end
  end

  initial begin : stim
    logic [N-1:0] cur;
    int           tmr[N];
    int           rcnt;
    tests = 0; fails = 0; done = 0;
    rst = 1'b1;
    key_in = '1;
    // reset with all keys held, then re-debounce after release of reset
    cyc(3'b000, 1'b1, 3);
    cyc(3'b000, 1'b0, 20);
    cyc(3'b111, 1'b0, 20);
    // clean press/release on key 0
    cyc(3'b110, 1'b0, 50);
    cyc(3'b111, 1'b0, 20);
    // press-side bounce on key 1
    for (int j = 0; j < 4; j++) begin
      cyc(3'b101, 1'b0, 5);
      cyc(3'b111, 1'b0, 3);
    end
    cyc(3'b111, 1'b0, 15);
    // release-side bounce while key 1 held
    cyc(3'b101, 1'b0, 20);
    for (int j = 0; j < 3; j++) begin
      cyc(3'b111, 1'b0, 5);
      cyc(3'b101, 1'b0, 3);
    end
    cyc(3'b101, 1'b0, 5);
    cyc(3'b111, 1'b0, 20);
    // independence: key 0 then key 2 four cycles later
    cyc(3'b110, 1'b0, 4);
    cyc(3'b010, 1'b0, 40);
    cyc(3'b111, 1'b0, 20);
    // reset mid-press
    cyc(3'b110, 1'b0, 20);
    cyc(3'b110, 1'b1, 2);
    cyc(3'b110, 1'b0, 20);
    cyc(3'b111, 1'b0, 20);
    // long hold
    cyc(3'b110, 1'b0, 100);
    cyc(3'b111, 1'b0, 20);
    // random glitches, holds and occasional resets
    cur = '1;
    rcnt = 0;
    for (int i = 0; i < N; i++) tmr[i] = $urandom_range(1, 30);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (tmr[i] == 0) begin
          cur[i] = ~cur[i];
          tmr[i] = cur[i] ? $urandom_range(1, 16)
                          : $urandom_range(1, 40);
        end else begin
          tmr[i]--;
        end
      end
      if (rcnt == 0 && $urandom_range(0, 399) == 0)
        rcnt = $urandom_range(1, 3);
      cyc(cur, rcnt != 0, 1);
      if (rcnt != 0) rcnt--;
    end
    cyc(3'b111, 1'b0, 30);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL queue_drain: got %0d left expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Input-side counterpart to the board's LED driver blocks: LEDs are driven out, push-buttons are read in.
- Synchronises and debounces KEY_NUM active-low push-buttons.
- Produces a clean debounced level plus single-cycle press and release pulses per key.
- Sits between the board key pins and the mode/control logic that selects LED flash and run patterns.

Parameters:
- KEY_NUM, 3, number of independent keys.
- DEBOUNCE_CYC, 1000000, stable-level cycles required to accept a change (20 ms at 50 MHz); minimum 2.
- LONG_CYC, 50000000, cycles a key must stay debounced-pressed before KEY_LONG fires (1 s at 50 MHz); used only with the optional feature.

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous, active-high reset.
- KEY_IN  input  KEY_NUM  raw key pins, active-low (0 = pressed), asynchronous to CLK.
- KEY_STATE  output  KEY_NUM  debounced level, 1 = pressed.
- KEY_PRESS  output  KEY_NUM  one-cycle pulse on accepted press.
- KEY_RELEASE  output  KEY_NUM  one-cycle pulse on accepted release.
- KEY_LONG  output  KEY_NUM  one-cycle long-press pulse (optional feature).

Behaviour:
- Clocking and reset:
  - One clock, CLK. Reset RST is asynchronous, active-high.
  - During or after reset: all synchroniser flops = 1 (released), every key FSM in IDLE, all counters = 0.
  - After reset: KEY_STATE, KEY_PRESS, KEY_RELEASE, KEY_LONG = 0.
- Synchroniser: each KEY_IN bit passes through a 2-flop synchroniser; s = second flop output.
- Per-key FSM: instantiated KEY_NUM times, fully independent, each with its own counter of width $clog2(max(DEBOUNCE_CYC, LONG_CYC)+1).
  - IDLE: s=0 -> PRESS_WAIT, cnt<=0. Otherwise stay.
  - PRESS_WAIT:
    - s=1 -> IDLE (bounce rejected, no pulse).
    - Else if cnt==DEBOUNCE_CYC-1 -> PRESSED, cnt<=0.
    - Else cnt<=cnt+1.
  - PRESSED: s=1 -> RELEASE_WAIT, cnt<=0.
  - RELEASE_WAIT:
    - s=0 -> PRESSED (bounce rejected, no pulse; long-press counter not restarted if already fired).
    - Else if cnt==DEBOUNCE_CYC-1 -> IDLE.
    - Else cnt<=cnt+1.
- Outputs, all registered:
  - KEY_STATE = 1 in PRESSED and RELEASE_WAIT.
  - KEY_PRESS = 1 for exactly the first cycle in PRESSED entered from PRESS_WAIT.
  - KEY_RELEASE = 1 for exactly the first cycle in IDLE entered from RELEASE_WAIT.
- Latency: KEY_IN change sampled at edge k, held stable -> pulse and KEY_STATE change visible after edge k+DEBOUNCE_CYC+3.
- Any glitch shorter than DEBOUNCE_CYC cycles (after synchronisation) produces no output change.
- Simultaneous presses on different keys produce pulses in the same cycle if the edges coincide.
- RST asserted mid-debounce or mid-press:
  - Immediate return to IDLE with outputs 0; no release pulse is generated.
  - A key still held when RST deasserts is re-debounced and yields a fresh KEY_PRESS.
- No output pulse is ever longer than one cycle.

Optional Feature:
- Macro: KEY_LONG_PRESS_EN.
- Defined:
  - In PRESSED and RELEASE_WAIT a per-key hold counter runs.
  - The hold counter clears on entry to PRESSED from PRESS_WAIT.
  - When the hold counter reaches LONG_CYC-1, KEY_LONG pulses for one cycle, once per press.
  - The hold counter saturates; it does not wrap.
  - No repeat until the key is released and pressed again.
- Undefined: KEY_LONG is tied to 0, no hold counter is synthesised, and LONG_CYC is ignored.

Test Plan:
- Reset check: RST=1 with KEY_IN=3'b000 -> all outputs 0. Deassert RST, DEBOUNCE_CYC=8 -> KEY_PRESS=3'b111 exactly 11 cycles after the first sampling edge.
- Clean press/release: DEBOUNCE_CYC=8, KEY_IN[0] 1->0 held 50 cycles, then 0->1.
  - KEY_PRESS[0] pulses one cycle at +11; KEY_STATE[0]=1 from +11.
  - KEY_RELEASE[0] pulses at +11 after release; KEY_STATE[0]=0 from the same cycle.
- Bounce rejection: KEY_IN[1] toggles low for 5 cycles, high for 3, repeated 4 times, then stays high -> no pulses, KEY_STATE[1] stays 0. Release-side bounces of 5 cycles while held -> no KEY_RELEASE.
- Independence: KEY_IN[0] pressed at cycle 0, KEY_IN[2] pressed at cycle 4 -> KEY_PRESS[0] at 11, KEY_PRESS[2] at 15, KEY_PRESS[1] never.
- Reset mid-press: key debounced-pressed, assert RST for 2 cycles while held -> outputs 0, no KEY_RELEASE. After deassert -> new KEY_PRESS 11 cycles later.
- With KEY_LONG_PRESS_EN, LONG_CYC=20, DEBOUNCE_CYC=8: hold KEY_IN[0] 100 cycles -> KEY_LONG[0] pulses exactly once, 20 cycles after KEY_PRESS[0]. Without the macro, KEY_LONG stays 0.
